// File: rtl/spart_rx_ctrl.sv
// spart_rx_ctrl: receive-side controller for the mini SPART.
// Generates the 16x baud tick, drains rx bytes into a FIFO with an rd_rx
// handshake, and exposes FIFO data, status and the baud divisor on the IO bus.
// Optional feature macro: RX_OVERRUN_DETECT_EN (accept and drop bytes while the
// FIFO is full, raising a sticky overrun flag); undefined = back-pressure rx.
module spart_rx_ctrl #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter logic [15:0] DIV_DEFAULT = 16'd325
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rda,
  input  logic [7:0] rx_data,
  output logic       rx_rd,
  output logic       baud_tick,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_e;

  // IO bus decode
  logic io_wr_c, io_rd_c, div_lo_wr_c, div_hi_wr_c;
  assign io_wr_c     = iocs & ~iorw;
  assign io_rd_c     = iocs & iorw;
  assign div_lo_wr_c = io_wr_c && (ioaddr == 2'b10);
  assign div_hi_wr_c = io_wr_c && (ioaddr == 2'b11);

  // ---------------------------------------------------------------------------
  // Baud generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Divisor byte updates; counter reloads on terminal count or any divisor write
  always_comb begin
    div_d = div_q;
    if (div_lo_wr_c) div_d[7:0]  = wr_data;
    if (div_hi_wr_c) div_d[15:8] = wr_data;
    if ((cnt_q == '0) || div_lo_wr_c || div_hi_wr_c) begin
      cnt_d = div_d;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Baud state registers; tick is registered so it coincides with cnt_q == 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_DEFAULT;
      cnt_q  <= DIV_DEFAULT;
      tick_q <= 1'(DIV_DEFAULT == '0);
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == '0);
    end
  end

  assign baud_tick = tick_q;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_c, full_c, push_c, pop_c;
  state_e            state_q, state_d;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign push_c  = (state_q == S_ACK) && !full_c;
  assign pop_c   = io_rd_c && (ioaddr == 2'b00) && !empty_c;

  // Pointer and occupancy update; simultaneous push and pop leave count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) mem_q[wr_ptr_q] <= rx_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun handling
  // ---------------------------------------------------------------------------
  logic accept_c;
  logic overrun_c;

`ifdef RX_OVERRUN_DETECT_EN
  logic overrun_q, overrun_d;
  logic ovr_set_c, stat_rd_c;

  assign accept_c  = 1'b1;
  assign ovr_set_c = (state_q == S_ACK) && full_c;
  assign stat_rd_c = io_rd_c && (ioaddr == 2'b01);

  // Sticky overrun: a status read clears it unless a new overrun lands that cycle
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_set_c) begin
      overrun_d = 1'b1;
    end else if (stat_rd_c) begin
      overrun_d = 1'b0;
    end
  end

  // Overrun flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun_c = overrun_q;
`else
  assign accept_c  = ~full_c;
  assign overrun_c = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  logic rx_rd_q;

  // Next-state logic: acknowledge one byte, then wait for rx to drop RDA
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (rx_rda && accept_c) state_d = S_ACK;
      S_ACK:      state_d = S_WAIT_CLR;
      S_WAIT_CLR: if (!rx_rda) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State register; rx_rd is registered high exactly while in ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rx_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_rd_q <= (state_d == S_ACK);
    end
  end

  assign rx_rd = rx_rd_q;

  // ---------------------------------------------------------------------------
  // CPU read mux
  // ---------------------------------------------------------------------------
  // Combinational read data; zero when nothing is selected or FIFO is empty
  always_comb begin
    rd_data = 8'h00;
    if (io_rd_c) begin
      case (ioaddr)
        2'b00:   rd_data = empty_c ? 8'h00 : mem_q[rd_ptr_q];
        2'b01:   rd_data = {4'b0000, overrun_c, full_c, ~empty_c, 1'b0};
        2'b10:   rd_data = div_q[7:0];
        default: rd_data = div_q[15:8];
      endcase
    end
  end

endmodule

// File: tb/tb_spart_rx_ctrl.sv
// Directed bench for spart_rx_ctrl: baud period, divisor writes, rx handshake,
// FIFO order/wrap, full behaviour and asynchronous reset.
module tb_spart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rda;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       baud_tick;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  spart_rx_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rda    (rx_rda),
    .rx_data   (rx_data),
    .rx_rd     (rx_rd),
    .baud_tick (baud_tick),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .wr_data   (wr_data),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until baud_tick is seen (-1 if not within limit)
  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (baud_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic io_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; wr_data = d;
    step();
    iocs = 1'b0; iorw = 1'b1;
  endtask

  task automatic io_read(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1;
    d = rd_data;
    step();
    iocs = 1'b0;
  endtask

  task automatic rx_present(input logic [7:0] d);
    rx_rda  = 1'b1;
    rx_data = d;
  endtask

  // Behaves like the rx block: waits for rd_rx, drops RDA one cycle later
  task automatic rx_wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (rx_rd === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) begin
      step();
      check1("rx_rd single pulse", rx_rd, 1'b0);
    end
    rx_rda = 1'b0;
    step();
  endtask

  task automatic rx_send(input logic [7:0] d);
    int lat;
    rx_present(d);
    rx_wait_ack(lat);
    checki("rx_rd latency", lat, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    int         lat;
    logic [7:0] d;

    rst_n = 1'b0; rx_rda = 1'b0; rx_data = 8'h00;
    iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; wr_data = 8'h00;

    // 1: reset state and default baud period
    #2;
    check1("reset rx_rd", rx_rd, 1'b0);
    check1("reset baud_tick", baud_tick, 1'b0);
    check8("reset rd_data idle", rd_data, 8'h00);
    @(posedge clk); #3; rst_n = 1'b1;
    wait_tick(400, n);
    checki("first tick after reset", n, 325);
    wait_tick(400, n);
    checki("default baud period", n, 326);
    step();
    check1("tick is one cycle", baud_tick, 1'b0);
    io_read(2'b01, d); check8("status after reset", d, 8'h00);
    io_read(2'b00, d); check8("empty data read", d, 8'h00);
    io_write(2'b00, 8'hFF);
    io_write(2'b01, 8'hFF);
    io_read(2'b01, d); check8("status after ignored writes", d, 8'h00);
    io_read(2'b00, d); check8("data after ignored writes", d, 8'h00);
    io_read(2'b10, d); check8("div low default", d, 8'h45);
    io_read(2'b11, d); check8("div high default", d, 8'h01);

    // 2: divisor = 4 gives a 5-cycle period starting after the write
    io_write(2'b10, 8'h04);
    io_write(2'b11, 8'h00);
    wait_tick(20, n); checki("first tick after div write", n, 4);
    wait_tick(20, n); checki("div4 period a", n, 5);
    wait_tick(20, n); checki("div4 period b", n, 5);
    io_read(2'b10, d); check8("div low readback", d, 8'h04);
    io_read(2'b11, d); check8("div high readback", d, 8'h00);
    // write landing on the terminal-count cycle
    wait_tick(20, n);
    check1("tick before tc write", baud_tick, 1'b1);
    io_write(2'b10, 8'h02);
    wait_tick(20, n); checki("tick after tc write", n, 2);
    wait_tick(20, n); checki("div2 period", n, 3);

    // 3: single byte
    rx_send(8'hA5);
    io_read(2'b01, d); check8("status one byte", d, 8'h02);
    io_read(2'b00, d); check8("read A5", d, 8'hA5);
    io_read(2'b01, d); check8("status drained", d, 8'h00);
    step();
    check1("rx_rd idle", rx_rd, 1'b0);

    // 4: fill with wrap, drain in order
    for (int i = 1; i <= 8; i++) rx_send(8'(i));
    io_read(2'b01, d); check8("status full", d, 8'h06);
    for (int i = 1; i <= 8; i++) begin
      io_read(2'b00, d); check8("wrap order", d, 8'(i));
    end
    io_read(2'b00, d); check8("ninth read empty", d, 8'h00);

    // 5: ninth byte while full
    for (int i = 1; i <= 8; i++) rx_send(8'(i));
`ifdef RX_OVERRUN_DETECT_EN
    rx_send(8'h09);
    io_read(2'b01, d); check8("status overrun", d, 8'h0E);
    io_read(2'b01, d); check8("status overrun cleared", d, 8'h06);
    for (int i = 1; i <= 8; i++) begin
      io_read(2'b00, d); check8("data intact after overrun", d, 8'(i));
    end
`else
    rx_present(8'h09);
    for (int i = 0; i < 4; i++) begin
      step();
      check1("rx_rd held while full", rx_rd, 1'b0);
    end
    io_read(2'b00, d); check8("pop while backpressured", d, 8'h01);
    rx_wait_ack(lat);
    checki("ack after pop latency", lat, 1);
    for (int i = 2; i <= 9; i++) begin
      io_read(2'b00, d); check8("data after backpressure", d, 8'(i));
    end
`endif
    io_read(2'b00, d); check8("empty after full test", d, 8'h00);
    io_read(2'b01, d); check8("status after full test", d, 8'h00);

    // 6: push and pop in the same cycle with three entries
    rx_send(8'h11); rx_send(8'h22); rx_send(8'h33);
    rx_present(8'h44);
    step();
    check1("rx_rd in ACK", rx_rd, 1'b1);
    io_read(2'b00, d); check8("pop during push", d, 8'h11);
    rx_rda = 1'b0;
    check1("rx_rd after ACK", rx_rd, 1'b0);
    step();
    io_read(2'b01, d); check8("status count 3", d, 8'h02);
    io_read(2'b00, d); check8("order 22", d, 8'h22);
    io_read(2'b00, d); check8("order 33", d, 8'h33);
    io_read(2'b00, d); check8("order 44", d, 8'h44);
    io_read(2'b00, d); check8("empty after concurrent", d, 8'h00);

    // reset asserted while in WAIT_CLR
    rx_present(8'h55);
    step();
    check1("rx_rd before reset", rx_rd, 1'b1);
    step();
    io_read(2'b01, d); check8("status before reset", d, 8'h02);
    rst_n = 1'b0;
    #1;
    check1("async reset rx_rd", rx_rd, 1'b0);
    check1("async reset baud_tick", baud_tick, 1'b0);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b01;
    #1; check8("async reset status", rd_data, 8'h00);
    ioaddr = 2'b00;
    #1; check8("async reset data", rd_data, 8'h00);
    ioaddr = 2'b10;
    #1; check8("async reset div low", rd_data, 8'h45);
    ioaddr = 2'b11;
    #1; check8("async reset div high", rd_data, 8'h01);
    iocs = 1'b0; rx_rda = 1'b0;
    @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
    wait_tick(400, n);
    checki("first tick after second reset", n, 325);
    rx_send(8'h66);
    io_read(2'b00, d); check8("byte after reset", d, 8'h66);
    io_read(2'b01, d); check8("final status", d, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
